legv8_dmem_master: RTL and testbench
====================================

Name: legv8_dmem_master

Overview:
- Requester-side controller for the LEGv8 data RAM (8-bit doubleword index, 64-bit data, separate writeEn/readEn, synchronous registered read).
- Accepts load/store requests from the CPU memory stage using a byte address and a valid/ready handshake.
- Checks alignment and range, then sequences the RAM enables.
- Returns one response per request: read data or write acknowledge, plus an error flag.

Parameters:
- ADDR_W, 8, RAM doubleword-index width; RAM depth is 2^ADDR_W doublewords.
- READ_LATENCY, 1, clock edges from readEn sampled high to RAM out being valid; legal range 1..7.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a CPU request is present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- resp_valid  out  1  response is present.
- resp_ready  in  1  CPU accepts the response.
- resp_rdata  out  64  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.
- mem_address  out  ADDR_W  RAM address.
- mem_in  out  64  RAM write data.
- mem_writeEn  out  1  RAM write enable.
- mem_readEn  out  1  RAM read enable.
- mem_out  in  64  RAM read data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE immediately.
  - All outputs are 0 except req_ready, which becomes 1 once reset is released.
  - Any in-flight request or pending response is discarded; no RAM enable may remain high.
  - Reset asserted mid-WRITE or mid-READ drops the enables in the same instant.
- States: IDLE, WRITE, READ, RESP. All mem_* outputs and resp_* outputs are registered.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, latch write, addr, and wdata.
  - Error check: error if req_addr[2:0]!=0 or req_addr[63:ADDR_W+3]!=0. On error, go to RESP with resp_err=1 and resp_rdata=0; no RAM access occurs.
  - Otherwise mem_address is set to req_addr[ADDR_W+2:3], and the next state is WRITE (store) or READ (load).
- WRITE:
  - Exactly one cycle with mem_writeEn=1, mem_in=wdata, mem_readEn=0.
  - Then RESP with resp_err=0 and resp_rdata=0.
- READ:
  - Lasts READ_LATENCY+1 cycles with mem_readEn=1 and mem_writeEn=0 throughout, tracked by a 3-bit down-counter.
  - mem_out is captured into resp_rdata on the edge that ends the final READ cycle; then RESP.
- RESP:
  - resp_valid=1, and resp_rdata/resp_err are held stable until an edge with resp_ready=1, then IDLE.
  - req_ready=0 here and in WRITE and READ.
  - Responses are never dropped or overwritten.
- Latency from the accept edge to resp_valid high:
  - store: 2 edges;
  - load: READ_LATENCY+2 edges;
  - error: 1 edge.
- mem_writeEn and mem_readEn are never both 1. Both are 0 in IDLE and RESP.
- mem_address and mem_in keep their last values when not in use.
- req_* inputs are ignored outside IDLE.
- Back-to-back operation: with resp_ready tied high, the next request can be accepted on the edge after RESP exits. Peak rate is one store per 3 cycles.
- Highest legal address: 0x7F8 (index 255). Address 0x800 is an error.

Test Plan:
- Reset released, store addr=0x38, wdata=8 → mem_address=7, mem_in=8, mem_writeEn high for exactly 1 cycle; resp_valid 2 edges after accept with resp_err=0 and resp_rdata=0.
- Load addr=0x38 after that store → mem_readEn high for READ_LATENCY+1 cycles; resp_rdata=8 and resp_err=0; mem_writeEn stays 0.
- Store addr=0x3C (misaligned), then store addr=0x800 (out of range) → resp_err=1 after 1 edge each; mem_writeEn and mem_readEn never assert; RAM index 7 still reads back 8.
- Load with resp_ready held low for 5 cycles → resp_valid and resp_rdata stay stable; req_ready=0; a new req_valid is ignored until the handshake completes.
- Store wdata=90 to addr=0x28, then load from 0x28 with resp_ready=1 → returns 90; the second request is accepted on the edge after the first response handshake.
- reset_n pulsed low during READ → mem_readEn drops immediately; no resp_valid is produced; after release req_ready=1 and a fresh load works.

Source files
------------

// File: rtl/legv8_dmem_master.sv
// Requester-side controller for the LEGv8 data RAM: checks each load/store for alignment
// and range, sequences the RAM enables, and returns one registered response per request.
module legv8_dmem_master #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_in,
  output logic              mem_writeEn,
  output logic              mem_readEn,
  input  logic [63:0]       mem_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [63:0]         mem_in_q, mem_in_d;
  logic                mem_writeEn_q, mem_writeEn_d;
  logic                mem_readEn_q, mem_readEn_d;
  logic                resp_valid_q, resp_valid_d;
  logic [63:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                addr_err;

  // Anything not doubleword aligned or beyond the RAM's byte span is rejected without a RAM access.
  assign addr_err = (req_addr[2:0] != 3'd0) || ((req_addr >> (ADDR_W + 3)) != 64'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      mem_address_q <= '0;
      mem_in_q      <= 64'd0;
      mem_writeEn_q <= 1'b0;
      mem_readEn_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 64'd0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      mem_writeEn_q <= mem_writeEn_d;
      mem_readEn_q  <= mem_readEn_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    mem_writeEn_d = mem_writeEn_q;
    mem_readEn_d  = mem_readEn_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else begin
            mem_address_d = req_addr[ADDR_W+2:3];
            if (req_write) begin
              state_d       = WRITE;
              mem_writeEn_d = 1'b1;
              mem_in_d      = req_wdata;
            end else begin
              state_d      = READ;
              mem_readEn_d = 1'b1;
              cnt_d        = 3'(READ_LATENCY);
            end
          end
        end
      end
      WRITE: begin
        state_d       = RESP;
        mem_writeEn_d = 1'b0;
        resp_valid_d  = 1'b1;
        resp_err_d    = 1'b0;
        resp_rdata_d  = 64'd0;
      end
      READ: begin
        // readEn stays high for READ_LATENCY+1 cycles; the last edge samples mem_out.
        if (cnt_q == 3'd0) begin
          state_d      = RESP;
          mem_readEn_d = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_out;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = reset_n && (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;
  assign mem_writeEn = mem_writeEn_q;
  assign mem_readEn  = mem_readEn_q;

endmodule

// File: tb/tb_legv8_dmem_master.sv
// Randomized bench for legv8_dmem_master: a behavioural RAM with configurable read latency plus
// a flat array reference model predicting each response, its latency and the enable pulse counts.
module tb_legv8_dmem_master;

  localparam int AW = 8;
  localparam int RL = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [63:0]   req_addr, req_wdata;
  logic          resp_valid, resp_ready;
  logic [63:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_in;
  logic          mem_writeEn, mem_readEn;
  logic [63:0]   mem_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] ram     [2**AW];
  logic [63:0] ref_mem [2**AW];
  logic [63:0] rd_pipe [RL];

  legv8_dmem_master #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_in(mem_in),
    .mem_writeEn(mem_writeEn), .mem_readEn(mem_readEn), .mem_out(mem_out)
  );

  always #5 clock = ~clock;

  // RAM: data for a readEn sampled on edge N appears on mem_out after edge N+RL-1.
  always @(posedge clock) begin
    if (mem_writeEn) ram[mem_address] <= mem_in;
    rd_pipe[0] <= mem_readEn ? ram[mem_address] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_out = rd_pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_req(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                         input int hold);
    bit          err;
    int          exp_lat, lat, wcnt, rcnt, both, waitc;
    logic [63:0] exp_data;
    logic [AW-1:0] idx;
    err      = (addr[2:0] != 3'd0) || (addr >= 64'h800);
    idx      = addr[AW+2:3];
    exp_lat  = err ? 1 : (wr ? 2 : RL + 2);
    exp_data = (err || wr) ? 64'd0 : ref_mem[idx];
    if (wr && !err) ref_mem[idx] = wdata;

    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    waitc = 0;
    while (!req_ready && waitc < 32) begin
      @(posedge clock); #1; waitc++;
    end
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    lat = 1; wcnt = 0; rcnt = 0; both = 0;
    forever begin
      if (mem_writeEn) begin
        wcnt++;
        chk("wr_address", {{(64-AW){1'b0}}, mem_address}, {{(64-AW){1'b0}}, idx});
        chk("wr_data", mem_in, wdata);
      end
      if (mem_readEn) begin
        rcnt++;
        chk("rd_address", {{(64-AW){1'b0}}, mem_address}, {{(64-AW){1'b0}}, idx});
      end
      if (mem_writeEn && mem_readEn) both++;
      if (resp_valid || lat >= 64) break;
      @(posedge clock); #1; lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("wr_cycles", 64'(wcnt), (wr && !err) ? 64'd1 : 64'd0);
    chk("rd_cycles", 64'(rcnt), (!wr && !err) ? 64'(RL + 1) : 64'd0);
    chk("both_enables", 64'(both), 64'd0);
    chk("resp_rdata", resp_rdata, exp_data);
    chk("resp_err", {63'd0, resp_err}, {63'd0, err});

    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_write = $urandom_range(0, 1);
      req_addr  = {53'd0, 8'($urandom), 3'd0};
      @(posedge clock); #1;
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, exp_data);
      chk("hold_err", {63'd0, resp_err}, {63'd0, err});
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_enables", {62'd0, mem_writeEn, mem_readEn}, 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("resp_done", {63'd0, resp_valid}, 64'd0);
    chk("ready_after_resp", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    int          quiet;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]     = 64'd0;
      ref_mem[i] = 64'd0;
    end
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_wdata  = 64'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_enables", {62'd0, mem_writeEn, mem_readEn}, 64'd0);
    chk("rst_mem_in", mem_in, 64'd0);
    chk("rst_mem_address", {{(64-AW){1'b0}}, mem_address}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

    run_req(1'b1, 64'h38, 64'd8, 0);
    run_req(1'b0, 64'h38, 64'd0, 0);
    run_req(1'b1, 64'h3C, 64'd5, 0);
    run_req(1'b1, 64'h800, 64'd6, 0);
    run_req(1'b0, 64'h38, 64'd0, 0);
    run_req(1'b0, 64'h38, 64'd0, 5);
    run_req(1'b1, 64'h28, 64'd90, 0);
    run_req(1'b0, 64'h28, 64'd0, 0);
    run_req(1'b1, 64'h7F8, 64'hFEED_0000_CAFE_0001, 0);
    run_req(1'b0, 64'h7F8, 64'd0, 1);
    run_req(1'b0, 64'h800, 64'd0, 0);

    // Reset in the middle of a load drops readEn at once and loses the response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h38;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("mid_read_readEn", {63'd0, mem_readEn}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_drops_readEn", {63'd0, mem_readEn}, 64'd0);
    chk("reset_drops_writeEn", {63'd0, mem_writeEn}, 64'd0);
    chk("reset_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    quiet = 0;
    repeat (RL + 4) begin
      @(posedge clock); #1;
      if (resp_valid || mem_readEn) quiet++;
    end
    chk("no_resp_after_reset", 64'(quiet), 64'd0);
    chk("ready_after_mid_reset", {63'd0, req_ready}, 64'd1);
    run_req(1'b0, 64'h38, 64'd0, 0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = {53'd0, 8'($urandom), 3'd0};
        3:       a = {53'd0, 8'($urandom), 3'($urandom_range(1, 7))};
        4: begin
          a = {$urandom, $urandom};
          a[$urandom_range(11, 63)] = 1'b1;
        end
        default: a = {53'd0, 8'($urandom_range(250, 255)), 3'd0};
      endcase
      run_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
